pipe_stage_reg: RTL

Parametrised pipeline stage register for inter-stage boundaries such as IF/ID, ID/EX and EX/MEM. It carries a packed payload through STAGES cascaded slots under a valid/ready handshake, with backpressure (stall) and synchronous flush. It replaces the free-running, always-load boundary registers: bubbles, stalls and branch flushes are handled inside the block instead of by the surrounding control logic. An optional skid buffer per slot breaks the combinational ready path.

---
 rtl/pipe_stage_reg_pkg.sv | 79 +++++++
 rtl/pipe_stage_reg_slot.sv | 85 ++++++++
 rtl/pipe_stage_reg.sv | 99 +++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// ============================================================================
// pipe_stage_reg_pkg : shared payload layouts for the pipeline boundary registers
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_stage_reg_pkg;

    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int SHIFT_OP_W = 12;
    localparam int STATUS_W   = 4;
    localparam int CTRL_W     = 8;
    localparam int EX_CMD_W   = 4;

    typedef enum logic [EX_CMD_W-1:0] {
        EX_NOP = 4'd0,
        EX_ADD = 4'd1,
        EX_SUB = 4'd2,
        EX_AND = 4'd3,
        EX_ORR = 4'd4,
        EX_EOR = 4'd5,
        EX_MOV = 4'd6,
        EX_CMP = 4'd7,
        EX_LDR = 4'd8,
        EX_STR = 4'd9,
        EX_BR  = 4'd10
    } ex_cmd_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    // First member sits at the MSB end; the *_LSB offsets below follow that order.
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       instr;
        logic [REG_IDX_W-1:0]  dst;
        logic [XLEN-1:0]       op_a;
        logic [XLEN-1:0]       op_b;
        logic [XLEN-1:0]       imm;
        logic [SHIFT_OP_W-1:0] shift_op;
        ex_cmd_e               cmd;
        logic [STATUS_W-1:0]   status;
        logic [CTRL_W-1:0]     ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      result;
        logic [XLEN-1:0]      store_data;
        logic [REG_IDX_W-1:0] dst;
        logic [STATUS_W-1:0]  status;
        logic [CTRL_W-1:0]    ctrl;
    } ex_mem_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);

    localparam int ID_EX_CTRL_LSB   = 0;
    localparam int ID_EX_STATUS_LSB = ID_EX_CTRL_LSB + CTRL_W;
    localparam int ID_EX_CMD_LSB    = ID_EX_STATUS_LSB + STATUS_W;
    localparam int ID_EX_SHIFT_LSB  = ID_EX_CMD_LSB + EX_CMD_W;
    localparam int ID_EX_IMM_LSB    = ID_EX_SHIFT_LSB + SHIFT_OP_W;
    localparam int ID_EX_OPB_LSB    = ID_EX_IMM_LSB + XLEN;
    localparam int ID_EX_OPA_LSB    = ID_EX_OPB_LSB + XLEN;
    localparam int ID_EX_DST_LSB    = ID_EX_OPA_LSB + XLEN;
    localparam int ID_EX_INSTR_LSB  = ID_EX_DST_LSB + REG_IDX_W;
    localparam int ID_EX_PC_LSB     = ID_EX_INSTR_LSB + XLEN;

    function automatic id_ex_t id_ex_unpack(input logic [ID_EX_W-1:0] raw);
        return id_ex_t'(raw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
// ============================================================================
// pipe_slot : one valid/ready pipeline slot; PIPE_SKID_EN adds a skid register
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    input  logic              dn_ready
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              main_open;

    // Ready comes straight from a flop, so out_ready never reaches in_ready.
    assign up_ready  = !skid_valid;
    assign accept    = up_valid && !skid_valid;
    assign main_open = !main_valid || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_open) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_data <= up_data;
                end
            end
        end else if (accept) begin
            skid_data  <= up_data;
            skid_valid <= 1'b1;
        end
    end
`else
    assign up_ready = !main_valid || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (up_ready) begin
            main_valid <= up_valid;
            if (up_valid) begin
                main_data <= up_data;
            end
        end
    end
`endif

    assign dn_valid = main_valid;
    assign dn_data  = main_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : STAGES cascaded valid/ready slots with flush and occupancy
// Optional: define PIPE_SKID_EN for a registered-ready skid buffer per slot.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int STAGES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(2*STAGES+1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES must be >= 1");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("pipe_stage_reg: DATA_W must be >= 1");
    end

    // Per-slot scopes keep each ready/valid link a separate net, so the
    // backward ready chain is not seen as a self-loop on one vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic              up_valid;
        logic              up_ready;
        logic [DATA_W-1:0] up_data;
        logic              dn_valid;
        logic              dn_ready;
        logic [DATA_W-1:0] dn_data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = g_slot[i-1].dn_valid;
            assign up_data  = g_slot[i-1].dn_data;
        end

        if (i == STAGES - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_chain
            assign dn_ready = g_slot[i+1].up_ready;
        end

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_ready (up_ready),
            .dn_valid (dn_valid),
            .dn_data  (dn_data),
            .dn_ready (dn_ready)
        );
    end

    assign in_ready  = g_slot[0].up_ready;
    assign out_valid = g_slot[STAGES-1].dn_valid;
    assign out_data  = g_slot[STAGES-1].dn_data;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_ONE;
        end else if (out_xfer && !in_xfer) begin
            occupancy <= occupancy - OCC_ONE;
        end
    end

endmodule

`default_nettype wire
